// File: rtl/img_proc_engine.sv
// Image-processing engine: v-mirror, grayscale, 3x3 sharpen and copy/h-mirror on an IMG_H x IMG_W RGB image.
// Build option IMG_PROC_HMIRROR_EN: mode 3 becomes a horizontal mirror instead of a straight copy.

module img_proc_engine #(
    parameter int  IMG_W = 64,
    parameter int  IMG_H = 64,
    parameter int  CH_W  = 8,
    localparam int RW    = $clog2(IMG_H),
    localparam int CW    = $clog2(IMG_W),
    localparam int PW    = 3 * CH_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [1:0]    mode_i,
    input  logic [PW-1:0] in_pix_i,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          out_we_o,
    output logic [RW-1:0] out_row_o,
    output logic [CW-1:0] out_col_o,
    output logic [PW-1:0] out_pix_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int AW = CH_W + 5;
    localparam logic [RW-1:0]        ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [CW-1:0]        COL_LAST   = CW'(IMG_W - 1);
    localparam logic signed [AW-1:0] PIX_MAX    = AW'((1 << CH_W) - 1);
    localparam logic [CH_W-1:0]      CH_ZERO    = '0;
    localparam logic [1:0]           MODE_VMIR  = 2'd0;
    localparam logic [1:0]           MODE_GRAY  = 2'd1;
    localparam logic [1:0]           MODE_SHARP = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_NB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic [RW-1:0]          r_q;
    logic [CW-1:0]          c_q;
    logic [3:0]             k_q;
    logic                   nbv_q;
    logic signed [AW-1:0]   acc_q;
    logic [RW-1:0]          row_q;
    logic [CW-1:0]          col_q;
    logic                   out_we_q;
    logic [RW-1:0]          out_row_q;
    logic [CW-1:0]          out_col_q;
    logic [PW-1:0]          out_pix_q;
    logic                   busy_q;
    logic                   done_q;

    logic [RW-1:0]          r_d;
    logic [CW-1:0]          c_d;
    logic                   last_d;
    logic [CH_W-1:0]        g_d;
    logic signed [AW-1:0]   g_ext_d;
    logic signed [AW-1:0]   term_d;
    logic signed [AW-1:0]   acc_d;
    logic [CH_W-1:0]        clamp_d;

    // Source address for the one-read modes; mirroring is just an address transform.
    function automatic logic [RW+CW-1:0] lin_addr(input logic [1:0] m,
                                                  input logic [RW-1:0] r,
                                                  input logic [CW-1:0] c);
        logic [RW-1:0] ar;
        logic [CW-1:0] ac;
        ar = (m == MODE_VMIR) ? (ROW_LAST - r) : r;
`ifdef IMG_PROC_HMIRROR_EN
        ac = (m == 2'd3) ? (COL_LAST - c) : c;
`else
        ac = c;
`endif
        return {ar, ac};
    endfunction

    // Neighbour k (row-major over the 3x3 window) of (r,c): {in-image flag, row, col}.
    function automatic logic [RW+CW:0] nb_addr(input logic [RW-1:0] r,
                                               input logic [CW-1:0] c,
                                               input logic [3:0]    k);
        int   rr;
        int   cc;
        logic v;
        rr = int'(r) + int'(k) / 32'sd3 - 32'sd1;
        cc = int'(c) + int'(k) % 32'sd3 - 32'sd1;
        v  = (rr >= 0) && (rr < IMG_H) && (cc >= 0) && (cc < IMG_W);
        if (v) begin
            return {1'b1, rr[RW-1:0], cc[CW-1:0]};
        end else begin
            return '0;
        end
    endfunction

    // Truncating midpoint of the brightest and darkest channel.
    function automatic logic [CH_W-1:0] gray(input logic [PW-1:0] p);
        logic [CH_W-1:0] cr, cg, cb, mx, mn;
        logic [CH_W:0]   s;
        cr = p[3*CH_W-1:2*CH_W];
        cg = p[2*CH_W-1:CH_W];
        cb = p[CH_W-1:0];
        mx = (cr > cg) ? cr : cg;
        mx = (cb > mx) ? cb : mx;
        mn = (cr < cg) ? cr : cg;
        mn = (cb < mn) ? cb : mn;
        s  = {1'b0, mx} + {1'b0, mn};
        return s[CH_W:1];
    endfunction

    // Raster advance of the destination pixel counter.
    always_comb begin
        last_d = (r_q == ROW_LAST) && (c_q == COL_LAST);
        if (c_q == COL_LAST) begin
            c_d = '0;
            r_d = r_q + RW'(1);
        end else begin
            c_d = c_q + CW'(1);
            r_d = r_q;
        end
    end

    // Sharpen accumulate: centre weighted 9, neighbours -1, off-image reads contribute nothing.
    always_comb begin
        g_d     = in_pix_i[2*CH_W-1:CH_W];
        g_ext_d = $signed({5'b00000, g_d});
        if (!nbv_q) begin
            term_d = '0;
        end else if (k_q == 4'd4) begin
            term_d = (g_ext_d <<< 3) + g_ext_d;
        end else begin
            term_d = -g_ext_d;
        end
        acc_d = acc_q + term_d;
        if (acc_d[AW-1]) begin
            clamp_d = '0;
        end else if (acc_d > PIX_MAX) begin
            clamp_d = '1;
        end else begin
            clamp_d = acc_d[CH_W-1:0];
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= 4'd0;
            nbv_q     <= 1'b0;
            acc_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            out_we_q  <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
            out_pix_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q   <= 1'b0;
                    out_we_q <= 1'b0;
                    // done_q still high means this is the done cycle; a start here is dropped.
                    if (start_i && !done_q) begin
                        mode_q <= mode_i;
                        r_q    <= '0;
                        c_q    <= '0;
                        k_q    <= 4'd0;
                        acc_q  <= '0;
                        busy_q <= 1'b1;
                        if (mode_i == MODE_SHARP) begin
                            {nbv_q, row_q, col_q} <= nb_addr('0, '0, 4'd0);
                            state_q               <= S_NB;
                        end else begin
                            {row_q, col_q} <= lin_addr(mode_i, '0, '0);
                            nbv_q          <= 1'b0;
                            state_q        <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    out_we_q  <= 1'b1;
                    out_row_q <= r_q;
                    out_col_q <= c_q;
                    if (mode_q == MODE_GRAY) begin
                        out_pix_q <= {CH_ZERO, gray(in_pix_i), CH_ZERO};
                    end else begin
                        out_pix_q <= in_pix_i;
                    end
                    state_q <= S_WR;
                end
                S_NB: begin
                    acc_q <= acc_d;
                    if (k_q == 4'd8) begin
                        out_we_q  <= 1'b1;
                        out_row_q <= r_q;
                        out_col_q <= c_q;
                        out_pix_q <= {CH_ZERO, clamp_d, CH_ZERO};
                        state_q   <= S_WR;
                    end else begin
                        k_q                   <= k_q + 4'd1;
                        {nbv_q, row_q, col_q} <= nb_addr(r_q, c_q, k_q + 4'd1);
                    end
                end
                S_WR: begin
                    out_we_q <= 1'b0;
                    if (last_d) begin
                        state_q <= S_DONE;
                    end else begin
                        r_q   <= r_d;
                        c_q   <= c_d;
                        k_q   <= 4'd0;
                        acc_q <= '0;
                        if (mode_q == MODE_SHARP) begin
                            {nbv_q, row_q, col_q} <= nb_addr(r_d, c_d, 4'd0);
                            state_q               <= S_NB;
                        end else begin
                            {row_q, col_q} <= lin_addr(mode_q, r_d, c_d);
                            state_q        <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    out_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign row_o     = row_q;
    assign col_o     = col_q;
    assign out_we_o  = out_we_q;
    assign out_row_o = out_row_q;
    assign out_col_o = out_col_q;
    assign out_pix_o = out_pix_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_img_proc_engine.sv
// Self-checking bench for img_proc_engine on a 4x4 image with a behavioural image model.
// Mode 3 expectations follow IMG_PROC_HMIRROR_EN in the same way as the design build.

module tb_img_proc_engine;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [23:0] in_pix_i;
    logic [1:0]  row_o, col_o, out_row_o, out_col_o;
    logic        out_we_o;
    logic [23:0] out_pix_o;
    logic        busy_o, done_o;

    logic [23:0] src_mem [H][W];
    logic [23:0] dst_mem [H][W];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int wr_cnt    = 0;
    int exp_idx   = 0;
    int order_err = 0;

    img_proc_engine #(.IMG_W(W), .IMG_H(H), .CH_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .mode_i    (mode_i),
        .in_pix_i  (in_pix_i),
        .row_o     (row_o),
        .col_o     (col_o),
        .out_we_o  (out_we_o),
        .out_row_o (out_row_o),
        .out_col_o (out_col_o),
        .out_pix_o (out_pix_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    assign in_pix_i = src_mem[row_o][col_o];

    // Destination memory plus raster-order tracking.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_we_o === 1'b1) begin
            if (int'(out_row_o) * W + int'(out_col_o) != exp_idx) order_err++;
            dst_mem[out_row_o][out_col_o] = out_pix_o;
            wr_cnt++;
            exp_idx++;
        end
    end

    function automatic logic [23:0] model_pix(input int m, input int r, input int c);
        logic [23:0] p;
        int cr, cg, cb, mx, mn, acc, g;
        case (m)
            0: return src_mem[H-1-r][c];
            1: begin
                p  = src_mem[r][c];
                cr = int'(p[23:16]);
                cg = int'(p[15:8]);
                cb = int'(p[7:0]);
                mx = cr; if (cg > mx) mx = cg; if (cb > mx) mx = cb;
                mn = cr; if (cg < mn) mn = cg; if (cb < mn) mn = cb;
                g  = (mx + mn) / 2;
                return {8'h00, g[7:0], 8'h00};
            end
            2: begin
                p   = src_mem[r][c];
                acc = 9 * int'(p[15:8]);
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
                            p   = src_mem[r+dr][c+dc];
                            acc = acc - int'(p[15:8]);
                        end
                    end
                end
                if (acc < 0) acc = 0;
                if (acc > 255) acc = 255;
                return {8'h00, acc[7:0], 8'h00};
            end
            default: begin
`ifdef IMG_PROC_HMIRROR_EN
                return src_mem[r][W-1-c];
`else
                return src_mem[r][c];
`endif
            end
        endcase
    endfunction

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                src_mem[r][c] = 24'($urandom);
    endtask

    task automatic fill_green(input logic [7:0] g);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                src_mem[r][c] = {8'($urandom), g, 8'($urandom)};
    endtask

    // Launch one operation and wait (bounded) for done; hold keeps start high throughout and into the done cycle.
    task automatic run_op(input logic [1:0] m, input bit hold, input int budget,
                          output int lat, output logic busy_at_done);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                dst_mem[r][c] = 'x;
        wr_cnt = 0; exp_idx = 0; order_err = 0;
        lat = -1; busy_at_done = 1'bx;
        @(negedge clk);
        mode_i = m; start_i = 1'b1;
        @(posedge clk);
        #1;
        mode_i = 2'($urandom);
        if (!hold) start_i = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk);
            #1;
            if (hold) mode_i = 2'($urandom);
            if (done_o === 1'b1) begin
                lat = cyc;
                busy_at_done = busy_o;
                break;
            end
        end
        if (hold) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] vals [8];
        rst_n = 1'b0; start_i = 1'b0; mode_i = 2'd0;
        fill_random();
        #12;
        vals = '{24'(row_o), 24'(col_o), 24'(out_we_o), 24'(out_row_o),
                 24'(out_col_o), out_pix_o, 24'(busy_o), 24'(done_o)};
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (vals[i] !== 24'h0) $display("FAIL reset_out%0d got=%h exp=0", i, vals[i]);
            else pass_cnt++;
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({busy_o, done_o, out_we_o} !== 3'b000) $display("FAIL idle_after_reset got=%b exp=000", {busy_o, done_o, out_we_o});
        else pass_cnt++;
    endtask

    task automatic test_vmirror();
        int lat; logic bz;
        fill_random();
        src_mem[0][0] = 24'h112233;
        run_op(2'd0, 1'b0, 100, lat, bz);
        total_cnt++; if (lat !== 33) $display("FAIL vmir_latency got=%0d exp=33", lat); else pass_cnt++;
        total_cnt++; if (bz !== 1'b0) $display("FAIL vmir_busy_at_done got=%b exp=0", bz); else pass_cnt++;
        total_cnt++; if (wr_cnt !== 16) $display("FAIL vmir_writes got=%0d exp=16", wr_cnt); else pass_cnt++;
        total_cnt++; if (order_err !== 0) $display("FAIL vmir_order got=%0d exp=0", order_err); else pass_cnt++;
        total_cnt++; if (dst_mem[3][0] !== 24'h112233) $display("FAIL vmir_30 got=%h exp=112233", dst_mem[3][0]); else pass_cnt++;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                total_cnt++;
                if (dst_mem[r][c] !== model_pix(0, r, c))
                    $display("FAIL vmir_pix r=%0d c=%0d got=%h exp=%h", r, c, dst_mem[r][c], model_pix(0, r, c));
                else pass_cnt++;
            end
    endtask

    task automatic test_grayscale();
        int lat; logic bz;
        fill_random();
        src_mem[0][0] = 24'h108040;
        src_mem[1][1] = 24'hFFFFFF;
        src_mem[2][2] = 24'h000000;
        run_op(2'd1, 1'b0, 100, lat, bz);
        total_cnt++; if (lat !== 33) $display("FAIL gray_latency got=%0d exp=33", lat); else pass_cnt++;
        total_cnt++; if (dst_mem[0][0] !== 24'h004800) $display("FAIL gray_108040 got=%h exp=004800", dst_mem[0][0]); else pass_cnt++;
        total_cnt++; if (dst_mem[1][1] !== 24'h00FF00) $display("FAIL gray_ffffff got=%h exp=00ff00", dst_mem[1][1]); else pass_cnt++;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                total_cnt++;
                if (dst_mem[r][c] !== model_pix(1, r, c))
                    $display("FAIL gray_pix r=%0d c=%0d got=%h exp=%h", r, c, dst_mem[r][c], model_pix(1, r, c));
                else pass_cnt++;
            end
    endtask

    task automatic test_sharpen();
        int lat; logic bz;
        for (int pat = 0; pat < 4; pat++) begin
            case (pat)
                0: fill_green(8'h20);
                1: fill_green(8'h40);
                2: begin fill_green(8'h10); src_mem[1][1][15:8] = 8'h00; end
                default: fill_random();
            endcase
            run_op(2'd2, 1'b0, 300, lat, bz);
            total_cnt++; if (lat !== 161) $display("FAIL sharp_latency pat=%0d got=%0d exp=161", pat, lat); else pass_cnt++;
            total_cnt++; if (wr_cnt !== 16 || order_err !== 0) $display("FAIL sharp_writes pat=%0d got=%0d/%0d exp=16/0", pat, wr_cnt, order_err); else pass_cnt++;
            if (pat == 0) begin
                total_cnt++; if (dst_mem[1][1] !== 24'h002000) $display("FAIL sharp_centre got=%h exp=002000", dst_mem[1][1]); else pass_cnt++;
                total_cnt++; if (dst_mem[0][0] !== 24'h00C000) $display("FAIL sharp_corner got=%h exp=00c000", dst_mem[0][0]); else pass_cnt++;
            end
            if (pat == 1) begin
                total_cnt++; if (dst_mem[0][0] !== 24'h00FF00) $display("FAIL sharp_clamp_hi got=%h exp=00ff00", dst_mem[0][0]); else pass_cnt++;
            end
            if (pat == 2) begin
                total_cnt++; if (dst_mem[1][1] !== 24'h000000) $display("FAIL sharp_clamp_lo got=%h exp=000000", dst_mem[1][1]); else pass_cnt++;
            end
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    total_cnt++;
                    if (dst_mem[r][c] !== model_pix(2, r, c))
                        $display("FAIL sharp_pix pat=%0d r=%0d c=%0d got=%h exp=%h", pat, r, c, dst_mem[r][c], model_pix(2, r, c));
                    else pass_cnt++;
                end
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; int saved; bit seen; logic bz;
        logic [23:0] vals [8];
        fill_random();
        wr_cnt = 0; exp_idx = 0; order_err = 0; seen = 0;
        @(negedge clk); mode_i = 2'd2; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(posedge clk);
            if (wr_cnt >= 5) begin seen = 1; break; end
        end
        total_cnt++; if (!seen) $display("FAIL midrst_reach5 got=%0d exp=5", wr_cnt); else pass_cnt++;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vals = '{24'(row_o), 24'(col_o), 24'(out_we_o), 24'(out_row_o),
                 24'(out_col_o), out_pix_o, 24'(busy_o), 24'(done_o)};
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (vals[i] !== 24'h0) $display("FAIL midrst_out%0d got=%h exp=0", i, vals[i]);
            else pass_cnt++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        saved = wr_cnt;
        repeat (200) @(posedge clk);
        #1;
        total_cnt++; if (wr_cnt !== saved) $display("FAIL midrst_no_writes got=%0d exp=%0d", wr_cnt, saved); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL midrst_idle got=%b exp=0", busy_o); else pass_cnt++;
        fill_random();
        run_op(2'd2, 1'b0, 300, lat, bz);
        total_cnt++; if (lat !== 161) $display("FAIL midrst_rerun_latency got=%0d exp=161", lat); else pass_cnt++;
        total_cnt++; if (wr_cnt !== 16) $display("FAIL midrst_rerun_writes got=%0d exp=16", wr_cnt); else pass_cnt++;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                total_cnt++;
                if (dst_mem[r][c] !== model_pix(2, r, c))
                    $display("FAIL midrst_pix r=%0d c=%0d got=%h exp=%h", r, c, dst_mem[r][c], model_pix(2, r, c));
                else pass_cnt++;
            end
    endtask

    task automatic test_back_to_back();
        int lat; logic bz;
        fill_random();
        run_op(2'd1, 1'b1, 100, lat, bz);
        total_cnt++; if (lat !== 33) $display("FAIL b2b_latency got=%0d exp=33", lat); else pass_cnt++;
        repeat (40) @(posedge clk);
        #1;
        total_cnt++; if (wr_cnt !== 16) $display("FAIL b2b_writes got=%0d exp=16", wr_cnt); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL b2b_no_restart got=%b exp=0", busy_o); else pass_cnt++;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                total_cnt++;
                if (dst_mem[r][c] !== model_pix(1, r, c))
                    $display("FAIL b2b_pix r=%0d c=%0d got=%h exp=%h", r, c, dst_mem[r][c], model_pix(1, r, c));
                else pass_cnt++;
            end
    endtask

    task automatic test_mode3();
        int lat; logic bz; logic [23:0] landed;
        fill_random();
        src_mem[0][0] = 24'hABCDEF;
        run_op(2'd3, 1'b0, 100, lat, bz);
`ifdef IMG_PROC_HMIRROR_EN
        landed = dst_mem[0][3];
`else
        landed = dst_mem[0][0];
`endif
        total_cnt++; if (lat !== 33) $display("FAIL m3_latency got=%0d exp=33", lat); else pass_cnt++;
        total_cnt++; if (landed !== 24'hABCDEF) $display("FAIL m3_landing got=%h exp=abcdef", landed); else pass_cnt++;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                total_cnt++;
                if (dst_mem[r][c] !== model_pix(3, r, c))
                    $display("FAIL m3_pix r=%0d c=%0d got=%h exp=%h", r, c, dst_mem[r][c], model_pix(3, r, c));
                else pass_cnt++;
            end
    endtask

    initial begin
        test_reset();
        test_vmirror();
        test_grayscale();
        test_sharpen();
        test_reset_mid_op();
        test_back_to_back();
        test_mode3();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
